dense_logits: RTL and testbench
===============================

// Module: dense_logits
// PURPOSE
//  Final fully-connected layer of the classifier. It takes INPUTS signed fixed-point features, one per handshake,
//  and computes VALUES class scores: bias + sum(w*x), using one shared multiplier for all MACs.
//  The scores drive the argmax (soft one-hot) stage directly downstream. Weights and biases are held in
//  internal registers and loaded through a simple write port.
// PARAMETERS
//  VALUES     3   number of output classes (neurons)
//  DATA_SIZE  8   width of features, weights, biases and scores (signed two's complement)
//  INPUTS     4   features per input vector
//  FRAC_BITS  4   fractional bits of weights; a weight of 1.0 is 1<<FRAC_BITS
//  ACC_SIZE   24  signed accumulator width
//  ADDR_W     $clog2(VALUES*INPUTS+VALUES)  weight/bias address width (derived; do not override)
// PORTS
//  clk        in   1          rising-edge clock
//  rst_n      in   1          asynchronous active-low reset
//  in_data    in   DATA_SIZE  signed feature x[k]
//  in_valid   in   1          feature valid
//  in_ready   out  1          block can accept a feature
//  wr_en      in   1          weight/bias write strobe
//  wr_addr    in   ADDR_W     address n*INPUTS+k gives w[n][k]; address VALUES*INPUTS+n gives bias[n]
//  wr_data    in   DATA_SIZE  signed write data
//  scores     out  DATA_SIZE x [0:VALUES-1]  signed class scores (unpacked array)
//  out_valid  out  1          scores valid
//  out_ready  in   1          consumer accepts scores
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - State becomes S_ACC. feature index k=0. Neuron index n=0.
//   - All accumulators, weights, biases and scores become 0. out_valid=0.
//   - in_ready=1 as soon as rst_n=1.
//  States:
//   - S_ACC: in_ready=1. On in_valid&&in_ready, latch in_data and go to S_MAC with n=0.
//   - S_MAC: one neuron per cycle, n=0..VALUES-1, in_ready=0.
//     acc[n] <= base + sext(x*w[n][k]).
//     base = sext(bias[n])<<<FRAC_BITS when k==0, otherwise base = acc[n].
//     After n=VALUES-1: if k<INPUTS-1 then k++ and go to S_ACC; otherwise go to S_FIN.
//   - S_FIN: one cycle. scores[n] <= sat(acc[n]>>>FRAC_BITS), clamped to [-2^(DATA_SIZE-1), 2^(DATA_SIZE-1)-1].
//     The shift is arithmetic (floor toward -inf). Set out_valid=1, k=0, go to S_OUT.
//   - S_OUT: in_ready=0. out_valid and scores are held stable. On out_valid&&out_ready, out_valid<=0 and
//     go to S_ACC. scores keep their last value after the handshake.
//  Timing:
//   - Each feature costs 1+VALUES cycles.
//   - out_valid rises VALUES+1 clock edges after the edge that accepts the last feature.
//  Arithmetic:
//   - The product is a full 2*DATA_SIZE-bit signed value, sign-extended to ACC_SIZE.
//   - The accumulator wraps modulo 2^ACC_SIZE and is never saturated mid-sum. Saturation happens only in S_FIN.
//  Writes:
//   - Accepted in any state. The new value is used by any MAC read on a later edge.
//   - Addresses >= VALUES*INPUTS+VALUES are ignored.
//  Other rules:
//   - in_data and in_valid are ignored whenever in_ready=0.
//   - rst_n low in any state aborts the vector immediately. No partial scores are emitted.
// TESTING
//  1. Reset, then idle -> scores all 0, out_valid=0, in_ready=1. Stream 4 zero features -> scores 0,0,0.
//  2. w[n][n]=16, all other weights 0, biases 0. Features 5,-3,7,1 -> scores {5,-3,7}.
//     out_valid rises exactly 4 edges after the 4th accept.
//  3. Saturation: all weights 127, features 127 x4 -> all scores 127.
//     Features -128 x4 -> all scores -128.
//  4. Flooring: bias[0]=3, w[0][0]=8, all else 0.
//     Features 1,0,0,0 -> scores[0]=3.
//     Features -1,0,0,0 -> scores[0]=2.
//  5. Backpressure: hold out_ready=0 for 10 cycles with in_valid=1 -> scores stable, in_ready=0,
//     no feature consumed. Raise out_ready -> one-cycle handshake, then in_ready=1.
//  6. Drop rst_n mid-S_MAC -> outputs 0 immediately. Rerun test 2 without rewriting weights -> scores {0,0,0}.

Source files
------------

// File: rtl/dense_logits.sv
// Purpose     : final fully-connected classifier layer, scores[n] = sat((bias[n]<<F + sum_k w[n][k]*x[k]) >>> F), one shared MAC.
// Latency     : each feature costs 1+VALUES cycles; out_valid rises VALUES+1 edges after the last feature is accepted.
// Backpressure: in_ready drops while MACs run and while scores wait in S_OUT; scores hold until out_valid&&out_ready.
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   in_data/in_valid/in_ready     signed feature stream, one feature per handshake
//   wr_en/wr_addr/wr_data         weight (n*INPUTS+k) and bias (VALUES*INPUTS+n) write port, usable in any state
//   scores/out_valid/out_ready    signed saturated class scores with valid/ready handshake
module dense_logits #(
    parameter int VALUES    = 3,
    parameter int DATA_SIZE = 8,
    parameter int INPUTS    = 4,
    parameter int FRAC_BITS = 4,
    parameter int ACC_SIZE  = 24,
    parameter int ADDR_W    = $clog2(VALUES*INPUTS+VALUES)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic signed [DATA_SIZE-1:0] in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        wr_en,
    input  logic        [ADDR_W-1:0]    wr_addr,
    input  logic signed [DATA_SIZE-1:0] wr_data,
    output logic signed [DATA_SIZE-1:0] scores [0:VALUES-1],
    output logic                        out_valid,
    input  logic                        out_ready
);

    localparam int NW  = (VALUES > 1) ? $clog2(VALUES) : 1;
    localparam int KW  = (INPUTS > 1) ? $clog2(INPUTS) : 1;
    localparam int NWT = VALUES*INPUTS;
    localparam int PW  = 2*DATA_SIZE;

    localparam logic [NW-1:0] N_LAST = NW'(VALUES-1);
    localparam logic [KW-1:0] K_LAST = KW'(INPUTS-1);
    localparam logic signed [ACC_SIZE-1:0] SAT_MAX = ACC_SIZE'((2**(DATA_SIZE-1))-1);
    localparam logic signed [ACC_SIZE-1:0] SAT_MIN = ACC_SIZE'(-(2**(DATA_SIZE-1)));

    typedef enum logic [1:0] {S_ACC, S_MAC, S_FIN, S_OUT} state_t;

    state_t                        state_q, state_d;
    logic [KW-1:0]                 k_q, k_d;
    logic [NW-1:0]                 n_q, n_d;
    logic                          out_valid_q, out_valid_d;
    logic signed [DATA_SIZE-1:0]   x_q;
    logic signed [DATA_SIZE-1:0]   w_q      [NWT];
    logic signed [DATA_SIZE-1:0]   b_q      [VALUES];
    logic signed [ACC_SIZE-1:0]    acc_q    [VALUES];
    logic signed [DATA_SIZE-1:0]   scores_q [VALUES];

    logic signed [DATA_SIZE-1:0]   w_sel, b_sel;
    logic signed [ACC_SIZE-1:0]    acc_sel, base, acc_d;
    logic signed [PW-1:0]          prod;
    logic signed [ACC_SIZE-1:0]    acc_sh   [VALUES];
    logic signed [DATA_SIZE-1:0]   sat_val  [VALUES];

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        n_d         = n_q;
        out_valid_d = out_valid_q;
        case (state_q)
            S_ACC: begin
                if (in_valid) begin
                    state_d = S_MAC;
                    n_d     = '0;
                end
            end
            S_MAC: begin
                if (n_q == N_LAST) begin
                    n_d = '0;
                    if (k_q == K_LAST) begin
                        state_d = S_FIN;
                    end else begin
                        k_d     = k_q + 1'b1;
                        state_d = S_ACC;
                    end
                end else begin
                    n_d = n_q + 1'b1;
                end
            end
            S_FIN: begin
                k_d         = '0;
                out_valid_d = 1'b1;
                state_d     = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_ACC;
                end
            end
            default: state_d = S_ACC;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_ACC;
            k_q         <= '0;
            n_q         <= '0;
            out_valid_q <= 1'b0;
            x_q         <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            n_q         <= n_d;
            out_valid_q <= out_valid_d;
            if (state_q == S_ACC && in_valid) begin
                x_q <= in_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Weight / bias storage; out-of-range addresses match no register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NWT; i++) begin
                w_q[i] <= '0;
            end
            for (int i = 0; i < VALUES; i++) begin
                b_q[i] <= '0;
            end
        end else if (wr_en) begin
            for (int i = 0; i < NWT; i++) begin
                if (wr_addr == ADDR_W'(i)) begin
                    w_q[i] <= wr_data;
                end
            end
            for (int i = 0; i < VALUES; i++) begin
                if (wr_addr == ADDR_W'(NWT+i)) begin
                    b_q[i] <= wr_data;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Shared MAC: operand select by (n, k), full-width product
    // ------------------------------------------------------------------
    always_comb begin
        w_sel   = '0;
        b_sel   = '0;
        acc_sel = '0;
        for (int n = 0; n < VALUES; n++) begin
            if (n_q == NW'(n)) begin
                b_sel   = b_q[n];
                acc_sel = acc_q[n];
                for (int k = 0; k < INPUTS; k++) begin
                    if (k_q == KW'(k)) begin
                        w_sel = w_q[n*INPUTS+k];
                    end
                end
            end
        end
    end

    // Operands are sign-extended to the product width first so the
    // multiply never truncates; the true product always fits in PW bits.
    assign prod = $signed({{DATA_SIZE{x_q[DATA_SIZE-1]}}, x_q})
                * $signed({{DATA_SIZE{w_sel[DATA_SIZE-1]}}, w_sel});

    // The first feature seeds the sum with the bias aligned to the
    // weight's fractional point; later features extend the running sum.
    assign base  = (k_q == '0)
                 ? ($signed({{(ACC_SIZE-DATA_SIZE){b_sel[DATA_SIZE-1]}}, b_sel}) <<< FRAC_BITS)
                 : acc_sel;
    assign acc_d = base + $signed({{(ACC_SIZE-PW){prod[PW-1]}}, prod});

    // Arithmetic shift floors toward -inf, then clamp to the score range.
    always_comb begin
        for (int i = 0; i < VALUES; i++) begin
            acc_sh[i]  = acc_q[i] >>> FRAC_BITS;
            sat_val[i] = acc_sh[i][DATA_SIZE-1:0];
            if (acc_sh[i] > SAT_MAX) begin
                sat_val[i] = SAT_MAX[DATA_SIZE-1:0];
            end else if (acc_sh[i] < SAT_MIN) begin
                sat_val[i] = SAT_MIN[DATA_SIZE-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < VALUES; i++) begin
                acc_q[i]    <= '0;
                scores_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < VALUES; i++) begin
                if (state_q == S_MAC && n_q == NW'(i)) begin
                    acc_q[i] <= acc_d;
                end
                if (state_q == S_FIN) begin
                    scores_q[i] <= sat_val[i];
                end
            end
        end
    end

    assign in_ready  = (state_q == S_ACC);
    assign out_valid = out_valid_q;
    assign scores    = scores_q;

endmodule

// File: tb/tb_dense_logits.sv
module tb_dense_logits;

    logic              clk = 1'b0;
    logic              rst_n;
    logic signed [7:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              wr_en;
    logic        [3:0] wr_addr;
    logic signed [7:0] wr_data;
    logic signed [7:0] scores [0:2];
    logic              out_valid;
    logic              out_ready;

    int          tests = 0;
    int          fails = 0;
    logic [23:0] exp_q [$];
    logic [23:0] mon_e;

    always #5 clk = ~clk;

    dense_logits dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .scores    (scores),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    function automatic logic [23:0] pk(input int a, input int b, input int c);
        return {8'(a), 8'(b), 8'(c)};
    endfunction

    // Monitor: samples after the negedge drives have settled, i.e. exactly
    // what the next rising edge will see for the output handshake.
    always @(negedge clk) begin
        #2;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_output: got scores %0d %0d %0d with no expected entry",
                         scores[0], scores[1], scores[2]);
            end else begin
                mon_e = exp_q.pop_front();
                for (int i = 0; i < 3; i++) begin
                    chk($sformatf("score%0d", i), int'(scores[i]), int'($signed(mon_e[23-8*i -: 8])));
                end
            end
        end
    end

    task automatic wr(input int addr, input int data);
        wr_en   = 1'b1;
        wr_addr = 4'(addr);
        wr_data = 8'(data);
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic load_diag();
        for (int n = 0; n < 3; n++)
            for (int k = 0; k < 4; k++)
                wr(n*4+k, (n == k) ? 16 : 0);
        for (int n = 0; n < 3; n++)
            wr(12+n, 0);
    endtask

    task automatic send_feat(input int x);
        int cnt = 0;
        in_data  = 8'(x);
        in_valid = 1'b1;
        while (!in_ready && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL feed_timeout: in_ready stayed 0, required 1");
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_vec(input int x0, input int x1, input int x2, input int x3,
                            input logic [23:0] e);
        int j = 0;
        exp_q.push_back(e);
        send_feat(x0);
        send_feat(x1);
        send_feat(x2);
        send_feat(x3);
        while (!out_valid && j < 20) begin
            @(negedge clk);
            j++;
        end
        if (!out_valid) begin
            tests++;
            fails++;
            $display("FAIL out_valid_timeout: out_valid 0 after %0d cycles, required 1", j);
        end else begin
            chk("out_valid_latency", j, 4);
        end
        if (out_ready) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 1. Reset state and an all-zero vector
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_in_ready", int'(in_ready), 1);
        chk("reset_score0", int'(scores[0]), 0);
        chk("reset_score1", int'(scores[1]), 0);
        chk("reset_score2", int'(scores[2]), 0);
        send_vec(0, 0, 0, 0, pk(0, 0, 0));

        // 2. Identity-like weights pass features 0..2 straight through
        load_diag();
        send_vec(5, -3, 7, 1, pk(5, -3, 7));

        // 3. Saturation both ways
        for (int i = 0; i < 12; i++) wr(i, 127);
        send_vec(127, 127, 127, 127, pk(127, 127, 127));
        send_vec(-128, -128, -128, -128, pk(-128, -128, -128));

        // 4. Flooring: (48+8)>>4 = 3, (48-8)>>4 = 2; address 15 is out of range
        for (int i = 0; i < 12; i++) wr(i, (i == 0) ? 8 : 0);
        wr(12, 3);
        wr(15, 85);
        send_vec(1, 0, 0, 0, pk(3, 0, 0));
        send_vec(-1, 0, 0, 0, pk(2, 0, 0));

        // 5. Backpressure: scores held, offered features ignored
        load_diag();
        out_ready = 1'b0;
        send_vec(5, -3, 7, 1, pk(5, -3, 7));
        in_data  = 8'(99);
        in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("bp_out_valid", int'(out_valid), 1);
            chk("bp_in_ready", int'(in_ready), 0);
            chk("bp_score0", int'(scores[0]), 5);
            chk("bp_score1", int'(scores[1]), -3);
            chk("bp_score2", int'(scores[2]), 7);
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(negedge clk);
        chk("bp_release_out_valid", int'(out_valid), 0);
        chk("bp_release_in_ready", int'(in_ready), 1);
        send_vec(5, -3, 7, 1, pk(5, -3, 7));

        // 6. Reset mid-MAC clears everything, including weights
        send_feat(5);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_score0", int'(scores[0]), 0);
        chk("rst_score1", int'(scores[1]), 0);
        chk("rst_score2", int'(scores[2]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_in_ready", int'(in_ready), 1);
        send_vec(5, -3, 7, 1, pk(0, 0, 0));

        repeat (5) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
